dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
//
// Each requester holds reqN high until it is granted. The owning port gets
// back-to-back accesses; while the other port waits, the owner is limited to
// MAX_BURST consecutive accesses before ownership hands over. Loads return
// data one cycle after the grant on the shared, registered rdata bus.
//
// Parameters:
//   AW        - address width (requesters and memory port)
//   DW        - data width
//   MAX_BURST - max consecutive accesses by one owner while the other waits (1..15)
//
// Ports:
//   clk, reset             - clock, asynchronous active-low reset
//   req0/1, we0/1          - per-port request and write select (1 = store)
//   addr0/1, wdata0/1      - per-port address and store data
//   gnt0/1                 - access accepted this cycle
//   rvalid0/1, rdata       - load data valid for that port, shared load data
//   mem_wr_en, mem_addr,
//   mem_dat_in, mem_dat_out - data memory port (combinational read)
//   owner                  - debug: 00 idle, 01 port 0 owns, 10 port 1 owns
//
// Configuration macro: DMEM_ARB_RR_EN selects round-robin resolution of
// simultaneous requests from idle; otherwise port 0 has fixed priority.

module dmem_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out,
  output logic [1:0]    owner
);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StOwn0 = 2'b01;
  localparam logic [1:0] StOwn1 = 2'b10;

  localparam logic [3:0] BurstMax = 4'(MAX_BURST);
  localparam logic [3:0] BurstSat = 4'hf;

  logic [1:0]    state_q, state_d;
  logic [3:0]    burst_q, burst_d;
  logic          last_served_q, last_served_d;
  logic [DW-1:0] rdata_q;
  logic          rvalid0_q, rvalid1_q;

  logic [3:0]    burst_inc;
  logic          limit_hit;
  logic [1:0]    both_pick;

  // Grants decode straight from state so they vanish as soon as reset asserts.
  assign gnt0  = (state_q == StOwn0) & req0;
  assign gnt1  = (state_q == StOwn1) & req1;
  assign owner = state_q;

  // Count of accesses in this ownership once the current grant completes.
  assign burst_inc = (burst_q == BurstSat) ? burst_q : burst_q + 4'd1;
  assign limit_hit = (burst_inc >= BurstMax);

`ifdef DMEM_ARB_RR_EN
  assign both_pick = last_served_q ? StOwn0 : StOwn1;
`else
  assign both_pick = StOwn0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = both_pick;
        end else if (req0) begin
          state_d = StOwn0;
        end else if (req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!req0) begin
          state_d = req1 ? StOwn1 : StIdle;
        end else if (req1 && limit_hit) begin
          state_d = StOwn1;
        end
      end
      StOwn1: begin
        if (!req1) begin
          state_d = req0 ? StOwn0 : StIdle;
        end else if (req0 && limit_hit) begin
          state_d = StOwn0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    burst_d = burst_q;
    if (state_d != state_q) begin
      burst_d = 4'd0;
    end else if (gnt0 || gnt1) begin
      burst_d = burst_inc;
    end
  end

  always_comb begin
    last_served_d = last_served_q;
    if (state_d != state_q) begin
      if (state_d == StOwn0) begin
        last_served_d = 1'b0;
      end else if (state_d == StOwn1) begin
        last_served_d = 1'b1;
      end
    end
  end

  // Memory port follows whichever port holds a grant; quiet (all zero) otherwise.
  always_comb begin
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    if (gnt0) begin
      mem_wr_en  = we0;
      mem_addr   = addr0;
      mem_dat_in = wdata0;
    end else if (gnt1) begin
      mem_wr_en  = we1;
      mem_addr   = addr1;
      mem_dat_in = wdata1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      burst_q       <= 4'd0;
      last_served_q <= 1'b1;
      rdata_q       <= '0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      last_served_q <= last_served_d;
      rvalid0_q     <= gnt0 & ~we0;
      rvalid1_q     <= gnt1 & ~we1;
      if ((gnt0 && !we0) || (gnt1 && !we1)) begin
        rdata_q <= mem_dat_out;
      end
    end
  end

  assign rdata   = rdata_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a small memory model
// and per-port load-data scoreboards.

module tb_dmem_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic       mem_wr_en;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
  logic [1:0] owner;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] mem [256];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  dmem_arbiter #(
    .AW        (8),
    .DW        (8),
    .MAX_BURST (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata       (rdata),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_dat_in  (mem_dat_in),
    .mem_dat_out (mem_dat_out),
    .owner       (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read, synchronous write.
  assign mem_dat_out = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
  end

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'ha5 : 8'((a * 7) + 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Load-data scoreboard: every rvalid pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (q0.size() == 0) check("rvalid0_spurious", 32'(rvalid0), 32'd0);
      else check("rdata_port0", 32'(rdata), 32'(q0.pop_front()));
    end
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) check("rvalid1_spurious", 32'(rvalid1), 32'd0);
      else check("rdata_port1", 32'(rdata), 32'(q1.pop_front()));
    end
  end

  // Inputs change 1 time unit after a rising edge; outputs are checked at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [7:0] a_tmp;
  logic       win1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    q0.push_back(8'ha5);

    // Reset state while port 0 already requests.
    mid();
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b1;

    // First grant one cycle after release, load of 0x10.
    tick();
    mid();
    check("first_gnt0", 32'(gnt0), 32'd1);
    check("first_owner", 32'(owner), 32'd1);
    check("first_mem_addr", 32'(mem_addr), 32'h10);
    check("first_wr_en", 32'(mem_wr_en), 32'd0);
    tick();
    req0 = 1'b0;
    mid();
    check("load_gnt0_off", 32'(gnt0), 32'd0);
    check("load_rvalid0", 32'(rvalid0), 32'd1);
    check("load_rvalid1", 32'(rvalid1), 32'd0);
    tick();
    mid();
    check("idle_owner", 32'(owner), 32'd0);
    check("idle_rvalid0", 32'(rvalid0), 32'd0);
    check("rdata_hold", 32'(rdata), 32'ha5);

    // Both request: port 0 bursts 4 loads, then port 1 stores with no idle gap.
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h3f; wdata1 = 8'h5a;
    q0.push_back(init_val(8'h20));
    mid();
    check("burst_wait_gnt0", 32'(gnt0), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      mid();
      check("burst_gnt0", 32'(gnt0), 32'd1);
      check("burst_gnt1", 32'(gnt1), 32'd0);
      check("burst_addr", 32'(mem_addr), 32'(8'h20 + i));
      tick();
      a_tmp = (i < 3) ? 8'(8'h21 + i) : 8'h30;
      addr0 = a_tmp;
      q0.push_back(init_val(a_tmp));
    end
    mid();
    check("handover_gnt0", 32'(gnt0), 32'd0);
    check("handover_gnt1", 32'(gnt1), 32'd1);
    check("handover_owner", 32'(owner), 32'd2);
    check("store_wr_en", 32'(mem_wr_en), 32'd1);
    check("store_addr", 32'(mem_addr), 32'h3f);
    check("store_data", 32'(mem_dat_in), 32'h5a);
    tick();
    req1 = 1'b0; we1 = 1'b0;
    mid();
    check("store_done_wr_en", 32'(mem_wr_en), 32'd0);
    check("store_no_rvalid1", 32'(rvalid1), 32'd0);
    check("mem_written", 32'(mem[8'h3f]), 32'h5a);
    tick();
    mid();
    check("back_to_port0", 32'(gnt0), 32'd1);
    check("back_addr", 32'(mem_addr), 32'h30);
    tick();
    req0 = 1'b0;
    tick();

    // Port 1 load of the stored value.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h3f;
    q1.push_back(8'h5a);
    tick();
    mid();
    check("p1_load_gnt1", 32'(gnt1), 32'd1);
    tick();
    req1 = 1'b0;
    mid();
    check("p1_load_rvalid0", 32'(rvalid0), 32'd0);
    check("p1_load_rvalid1", 32'(rvalid1), 32'd1);
    tick();

    // Simultaneous requests from idle, twice.
    for (int r = 0; r < 2; r++) begin
`ifdef DMEM_ARB_RR_EN
      win1 = (r == 1);
`else
      win1 = 1'b0;
`endif
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'h41;
      if (win1) q1.push_back(init_val(8'h41));
      else q0.push_back(init_val(8'h40));
      tick();
      mid();
      check("tie_gnt0", 32'(gnt0), win1 ? 32'd0 : 32'd1);
      check("tie_gnt1", 32'(gnt1), win1 ? 32'd1 : 32'd0);
      tick();
      req0 = 1'b0; req1 = 1'b0;
      tick();
      mid();
      check("tie_idle", 32'(owner), 32'd0);
      tick();
    end

    // Reset asserted mid-burst while port 1 has a load in flight.
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h41;
    q1.push_back(init_val(8'h41));
    tick();
    mid();
    check("pre_rst_gnt1", 32'(gnt1), 32'd1);
    tick();
    mid();
    reset = 1'b0;
    #1;
    check("rst_mid_gnt1", 32'(gnt1), 32'd0);
    check("rst_mid_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_mid_owner", 32'(owner), 32'd0);
    check("rst_mid_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_mid_rdata", 32'(rdata), 32'd0);
    tick();
    req1 = 1'b0;
    mid();
    check("rst_hold_rvalid1", 32'(rvalid1), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    mid();
    check("post_rst_owner", 32'(owner), 32'd0);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
